// File: rtl/program_loader.sv
// program_loader: receives a length-prefixed, checksummed byte stream from a
// host and writes it as 16-bit words into instruction RAM, holding the CPU
// until the image has been loaded and the checksum has been verified.
//
// Stream layout: LEN (word count N), then N words as hi byte / lo byte,
// then CHK = XOR of the 2N data bytes (LEN not included).
module program_loader #(
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [7:0]  iram_addr,
    output logic [15:0] iram_data,
    output logic        iram_enable,
    output logic        iram_write_en,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_error,
    output logic [8:0]  word_count
);

    // A word count can never exceed what fits in the 8-bit LEN byte, so the
    // limit is clamped to that range before it is used in comparisons.
    localparam int MAX_CLAMP = (MAX_WORDS > 255) ? 255 : ((MAX_WORDS < 0) ? 0 : MAX_WORDS);
    localparam logic [7:0] MAX_LEN   = 8'(MAX_CLAMP);
    localparam logic [9:0] BASE_EXT  = 10'(BASE_ADDR);
    localparam logic [7:0] BASE_BYTE = 8'(BASE_ADDR);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        HI    = 3'd2,
        LO    = 3'd3,
        WRITE = 3'd4,
        CHK   = 3'd5,
        DONE  = 3'd6,
        ERR   = 3'd7
    } loaderState;

    loaderState stateReg;
    loaderState stateNext;

    logic [7:0] lenReg;        // latched word count N
    logic [7:0] hiReg;         // hi byte of the word being assembled
    logic [7:0] accReg;        // running XOR of data bytes
    logic [7:0] wrPtr;         // address the next word will be written to
    logic [8:0] wordCountReg;  // words written in this load
    logic [7:0] addrReg;       // address presented to instruction RAM
    logic [15:0] dataReg;      // word presented to instruction RAM

    logic       xfer;
    logic       canStart;
    logic       lenBad;
    logic [9:0] lenEnd;
    logic       lastWord;
    logic       chkGood;
    logic       readyDec;
    logic       writeDec;

    // A byte moves only when the host offers one and the loader wants one.
    assign xfer = byte_valid & readyDec;

    // A new load may only be launched from a resting state.
    assign canStart = start & ((stateReg == IDLE) | (stateReg == DONE) | (stateReg == ERR));

    // One past the last address the image would occupy; above 256 means the
    // image would run off the end of the RAM, which is rejected rather than
    // wrapped.
    assign lenEnd = BASE_EXT + {2'b00, byte_in};
    assign lenBad = (byte_in == 8'd0) | (byte_in > MAX_LEN) | (lenEnd > 10'd256);

    // True while in WRITE when the word being written is the final one.
    assign lastWord = ((wordCountReg + 9'd1) == {1'b0, lenReg});

    assign chkGood = (byte_in == accReg);

    // State register: synchronous active-low reset forces IDLE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Next-state logic: resting states respond to start, loading states
    // advance only on a byte transfer (WRITE advances unconditionally).
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE, DONE, ERR: begin
                if (canStart) begin
                    stateNext = LEN;
                end else begin
                    stateNext = stateReg;
                end
            end
            LEN: begin
                if (xfer) begin
                    if (lenBad) begin
                        stateNext = ERR;
                    end else begin
                        stateNext = HI;
                    end
                end else begin
                    stateNext = LEN;
                end
            end
            HI: begin
                if (xfer) begin
                    stateNext = LO;
                end else begin
                    stateNext = HI;
                end
            end
            LO: begin
                if (xfer) begin
                    stateNext = WRITE;
                end else begin
                    stateNext = LO;
                end
            end
            WRITE: begin
                if (lastWord) begin
                    stateNext = CHK;
                end else begin
                    stateNext = HI;
                end
            end
            CHK: begin
                if (xfer) begin
                    if (chkGood) begin
                        stateNext = DONE;
                    end else begin
                        stateNext = ERR;
                    end
                end else begin
                    stateNext = CHK;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Output decode from the current state. The write strobe is also gated
    // by reset so a word pending in WRITE is dropped when reset arrives in
    // that same cycle.
    always_comb begin
        readyDec   = 1'b0;
        writeDec   = 1'b0;
        cpu_hold   = 1'b0;
        load_done  = 1'b0;
        load_error = 1'b0;
        case (stateReg)
            IDLE: begin
                cpu_hold = 1'b0;
            end
            LEN, HI, LO, CHK: begin
                readyDec = 1'b1;
                cpu_hold = 1'b1;
            end
            WRITE: begin
                writeDec = reset;
                cpu_hold = 1'b1;
            end
            DONE: begin
                load_done = 1'b1;
            end
            ERR: begin
                cpu_hold   = 1'b1;
                load_error = 1'b1;
            end
            default: begin
                cpu_hold = 1'b0;
            end
        endcase
    end

    assign byte_ready    = readyDec;
    assign iram_write_en = writeDec;
    assign iram_enable   = writeDec;
    assign iram_addr     = addrReg;
    assign iram_data     = dataReg;
    assign word_count    = wordCountReg;

    // Datapath: length, byte assembly, checksum accumulation, and the RAM
    // address/data registers, which change only when a word is completed so
    // they hold steady outside the write strobe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lenReg       <= 8'd0;
            hiReg        <= 8'd0;
            accReg       <= 8'd0;
            wrPtr        <= 8'd0;
            wordCountReg <= 9'd0;
            addrReg      <= 8'd0;
            dataReg      <= 16'd0;
        end else begin
            case (stateReg)
                IDLE, DONE, ERR: begin
                    if (canStart) begin
                        lenReg       <= 8'd0;
                        accReg       <= 8'd0;
                        wrPtr        <= BASE_BYTE;
                        wordCountReg <= 9'd0;
                    end
                end
                LEN: begin
                    if (xfer && !lenBad) begin
                        lenReg <= byte_in;
                    end
                end
                HI: begin
                    if (xfer) begin
                        hiReg  <= byte_in;
                        accReg <= accReg ^ byte_in;
                    end
                end
                LO: begin
                    if (xfer) begin
                        accReg  <= accReg ^ byte_in;
                        dataReg <= {hiReg, byte_in};
                        addrReg <= wrPtr;
                    end
                end
                WRITE: begin
                    wordCountReg <= wordCountReg + 9'd1;
                    // The pointer stops at the final address instead of
                    // stepping past 255 on the last word.
                    if (!lastWord) begin
                        wrPtr <= wrPtr + 8'd1;
                    end
                end
                CHK: begin
                    accReg <= accReg;
                end
                default: begin
                    accReg <= accReg;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader: two instances (base 0 and base 250)
// share the stimulus; a negedge monitor logs every write strobe.
module tb_program_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;

    logic        rdy0, wen0, en0, hold0, done0, err0;
    logic [7:0]  addr0;
    logic [15:0] data0;
    logic [8:0]  wc0;

    logic        rdy1, wen1, en1, hold1, done1, err1;
    logic [7:0]  addr1;
    logic [15:0] data1;
    logic [8:0]  wc1;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0]  wAddr0 [64];
    logic [15:0] wData0 [64];
    logic [7:0]  wAddr1 [64];
    logic [15:0] wData1 [64];
    int wCnt0 = 0;
    int wCnt1 = 0;
    int enBad = 0;

    program_loader dut0 (
        .clk(clk), .reset(reset), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(rdy0), .iram_addr(addr0),
        .iram_data(data0), .iram_enable(en0), .iram_write_en(wen0),
        .cpu_hold(hold0), .load_done(done0), .load_error(err0), .word_count(wc0)
    );

    program_loader #(.BASE_ADDR(250)) dut1 (
        .clk(clk), .reset(reset), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(rdy1), .iram_addr(addr1),
        .iram_data(data1), .iram_enable(en1), .iram_write_en(wen1),
        .cpu_hold(hold1), .load_done(done1), .load_error(err1), .word_count(wc1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    // Write-strobe monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (wen0 === 1'b1) begin
            if (wCnt0 < 64) begin
                wAddr0[wCnt0] <= addr0;
                wData0[wCnt0] <= data0;
            end
            wCnt0 <= wCnt0 + 1;
        end
        if (wen1 === 1'b1) begin
            if (wCnt1 < 64) begin
                wAddr1[wCnt1] <= addr1;
                wData1[wCnt1] <= data1;
            end
            wCnt1 <= wCnt1 + 1;
        end
        if ((wen0 !== en0) || (wen1 !== en1)) enBad <= enBad + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Offer one byte after 'gap' idle cycles (optionally pulsing start in
    // them) and wait, bounded, until the chosen instance accepts it.
    task automatic sendByte(input logic [7:0] b, input int gap, input logic pulse, input logic useDut1);
        logic seen;
        byte_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            start = pulse;
            @(posedge clk); #1;
            start = 1'b0;
        end
        byte_in = b;
        byte_valid = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if ((useDut1 ? rdy1 : rdy0) === 1'b1) begin
                seen = 1'b1;
                @(posedge clk); #1;
            end
        end
        byte_valid = 1'b0;
        if (!seen) chk("handshake_timeout", {31'd0, seen}, 32'd1);
    endtask

    task automatic doReset();
        reset = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    initial begin
        int base;
        int base1;
        int t0;
        reset = 1'b0; start = 1'b0; byte_in = 8'h00; byte_valid = 1'b0;
        doReset();

        // Reset state
        chk("rst_ready", {31'd0, rdy0}, 32'd0);
        chk("rst_hold",  {31'd0, hold0}, 32'd0);
        chk("rst_done_err", {30'd0, done0, err0}, 32'd0);
        chk("rst_wc",    {23'd0, wc0}, 32'd0);
        chk("rst_addr_data", {8'd0, addr0, data0}, 32'd0);

        // Basic two-word load, back-to-back bytes
        base = wCnt0;
        pulseStart();
        t0 = cyc;
        chk("start_hold", {31'd0, hold0}, 32'd1);
        chk("start_ready", {31'd0, rdy0}, 32'd1);
        sendByte(8'h02, 0, 1'b0, 1'b0);
        sendByte(8'h12, 0, 1'b0, 1'b0);
        sendByte(8'h34, 0, 1'b0, 1'b0);
        sendByte(8'hAB, 0, 1'b0, 1'b0);
        sendByte(8'hCD, 0, 1'b0, 1'b0);
        sendByte(8'h40, 0, 1'b0, 1'b0);
        chk("basic_latency", 32'(cyc - t0), 32'd8);
        chk("basic_done", {29'd0, done0, hold0, err0}, 32'b100);
        chk("basic_wc", {23'd0, wc0}, 32'd2);
        chk("basic_nwrites", 32'(wCnt0 - base), 32'd2);
        chk("basic_w0", {8'd0, wAddr0[base], wData0[base]}, 32'h00_1234);
        chk("basic_w1", {8'd0, wAddr0[base+1], wData0[base+1]}, 32'h01_ABCD);
        chk("basic_hold_regs", {8'd0, addr0, data0}, 32'h01_ABCD);

        // Zero length -> error, then retry with a good stream
        base = wCnt0;
        pulseStart();
        chk("retry_wc_clear", {23'd0, wc0}, 32'd0);
        sendByte(8'h00, 0, 1'b0, 1'b0);
        chk("len0_err", {29'd0, done0, hold0, err0}, 32'b011);
        chk("len0_nowrite", 32'(wCnt0 - base), 32'd0);
        pulseStart();
        sendByte(8'h01, 0, 1'b0, 1'b0);
        sendByte(8'h01, 0, 1'b0, 1'b0);
        sendByte(8'h02, 0, 1'b0, 1'b0);
        sendByte(8'h03, 0, 1'b0, 1'b0);
        chk("retry_done", {29'd0, done0, hold0, err0}, 32'b100);
        chk("retry_w0", {8'd0, wAddr0[base], wData0[base]}, 32'h00_0102);

        // Bad checksum -> word written, then error
        base = wCnt0;
        pulseStart();
        sendByte(8'h01, 0, 1'b0, 1'b0);
        sendByte(8'h5A, 0, 1'b0, 1'b0);
        sendByte(8'h5A, 0, 1'b0, 1'b0);
        sendByte(8'h01, 0, 1'b0, 1'b0);
        chk("badchk_err", {29'd0, done0, hold0, err0}, 32'b011);
        chk("badchk_nwrites", 32'(wCnt0 - base), 32'd1);
        chk("badchk_w0", {8'd0, wAddr0[base], wData0[base]}, 32'h00_5A5A);

        // Three words with gaps and ignored start pulses mid-load
        base = wCnt0;
        pulseStart();
        sendByte(8'h03, 0, 1'b0, 1'b0);
        sendByte(8'h11, 1, 1'b1, 1'b0);
        sendByte(8'h11, 1, 1'b1, 1'b0);
        sendByte(8'h22, 1, 1'b1, 1'b0);
        sendByte(8'h22, 1, 1'b1, 1'b0);
        sendByte(8'h43, 1, 1'b1, 1'b0);
        sendByte(8'h21, 1, 1'b1, 1'b0);
        sendByte(8'h62, 1, 1'b1, 1'b0);
        chk("gap_done", {29'd0, done0, hold0, err0}, 32'b100);
        chk("gap_wc", {23'd0, wc0}, 32'd3);
        chk("gap_nwrites", 32'(wCnt0 - base), 32'd3);
        chk("gap_w0", {8'd0, wAddr0[base], wData0[base]}, 32'h00_1111);
        chk("gap_w1", {8'd0, wAddr0[base+1], wData0[base+1]}, 32'h01_2222);
        chk("gap_w2", {8'd0, wAddr0[base+2], wData0[base+2]}, 32'h02_4321);

        // Reset in the WRITE cycle of word 2 of 4
        base = wCnt0;
        pulseStart();
        sendByte(8'h04, 0, 1'b0, 1'b0);
        sendByte(8'hA1, 0, 1'b0, 1'b0);
        sendByte(8'hB2, 0, 1'b0, 1'b0);
        sendByte(8'hC3, 0, 1'b0, 1'b0);
        sendByte(8'hD4, 0, 1'b0, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk("rstmid_strobe", {31'd0, wen0}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        chk("rstmid_nwrites", 32'(wCnt0 - base), 32'd1);
        chk("rstmid_flags", {28'd0, rdy0, done0, hold0, err0}, 32'd0);
        chk("rstmid_wc", {23'd0, wc0}, 32'd0);
        chk("rstmid_addr_data", {8'd0, addr0, data0}, 32'd0);
        base = wCnt0;
        pulseStart();
        sendByte(8'h04, 0, 1'b0, 1'b0);
        sendByte(8'h10, 0, 1'b0, 1'b0); sendByte(8'h01, 0, 1'b0, 1'b0);
        sendByte(8'h20, 0, 1'b0, 1'b0); sendByte(8'h02, 0, 1'b0, 1'b0);
        sendByte(8'h30, 0, 1'b0, 1'b0); sendByte(8'h03, 0, 1'b0, 1'b0);
        sendByte(8'h40, 0, 1'b0, 1'b0); sendByte(8'h04, 0, 1'b0, 1'b0);
        sendByte(8'h44, 0, 1'b0, 1'b0);
        chk("reload_done", {29'd0, done0, hold0, err0}, 32'b100);
        chk("reload_nwrites", 32'(wCnt0 - base), 32'd4);
        chk("reload_w0", {8'd0, wAddr0[base], wData0[base]}, 32'h00_1001);
        chk("reload_w3", {8'd0, wAddr0[base+3], wData0[base+3]}, 32'h03_4004);

        // Base address 250: LEN 7 overruns, LEN 6 ends exactly at 255
        doReset();
        base1 = wCnt1;
        pulseStart();
        sendByte(8'h07, 0, 1'b0, 1'b1);
        chk("b250_len7_err", {29'd0, done1, hold1, err1}, 32'b011);
        chk("b250_len7_nowrite", 32'(wCnt1 - base1), 32'd0);
        pulseStart();
        sendByte(8'h06, 0, 1'b0, 1'b1);
        for (int w = 1; w <= 6; w++) begin
            sendByte(8'h10, 0, 1'b0, 1'b1);
            sendByte(8'(w), 0, 1'b0, 1'b1);
        end
        sendByte(8'h07, 0, 1'b0, 1'b1);
        chk("b250_done", {29'd0, done1, hold1, err1}, 32'b100);
        chk("b250_wc", {23'd0, wc1}, 32'd6);
        chk("b250_nwrites", 32'(wCnt1 - base1), 32'd6);
        chk("b250_first", {8'd0, wAddr1[base1], wData1[base1]}, 32'hFA_1001);
        chk("b250_last", {8'd0, wAddr1[base1+5], wData1[base1+5]}, 32'hFF_1006);
        chk("b250_hold_addr", {24'd0, addr1}, 32'd255);

        chk("enable_eq_wen", 32'(enBad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter BASE_ADDR, default 0: first instruction-RAM address written.
REQ-002 Parameter MAX_WORDS, default 255: largest legal word count.
REQ-003 clk  input  1  system clock, all state changes on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-low; one clock; no other clock or async reset.
REQ-005 start  input  1  single-cycle request to begin a program load.
REQ-006 byte_in  input  8  host load-stream byte.
REQ-007 byte_valid  input  1  byte_in holds a valid byte.
REQ-008 byte_ready  output  1  loader accepts byte this cycle; transfer = byte_valid & byte_ready.
REQ-009 iram_addr  output  8  instruction-RAM write address.
REQ-010 iram_data  output  16  instruction word {hi byte, lo byte}.
REQ-011 iram_enable  output  1  instruction-RAM enable, equal to iram_write_en.
REQ-012 iram_write_en  output  1  one-cycle write strobe per word.
REQ-013 cpu_hold  output  1  holds the controller and PC while the load is in progress.
REQ-014 load_done  output  1  load completed with a good checksum.
REQ-015 load_error  output  1  load aborted: bad length or bad checksum.
REQ-016 word_count  output  9  words written in the current load.

Function
REQ-017 Stream format SHALL be LEN byte N, then N words sent as hi byte then lo byte, then CHK byte.
REQ-018 CHK SHALL equal the XOR of all 2N data bytes; LEN SHALL be excluded from CHK.
REQ-019 States SHALL be IDLE, LEN, HI, LO, WRITE, CHK, DONE, ERR.
REQ-020 IDLE/DONE/ERR + start -> LEN; cpu_hold=1, load_done=0, load_error=0, word_count=0, checksum accumulator=0, addr=BASE_ADDR.
REQ-021 start SHALL be ignored in LEN, HI, LO, WRITE, CHK.
REQ-022 byte_ready SHALL be 1 only in LEN, HI, LO, CHK; a state advances only on a transfer.
REQ-023 LEN transfer: if N==0, N>MAX_WORDS, or BASE_ADDR+N>256 -> ERR; else latch N -> HI.
REQ-024 HI transfer: latch hi byte, XOR into accumulator -> LO.
REQ-025 LO transfer: latch lo byte, XOR into accumulator -> WRITE.
REQ-026 WRITE: iram_write_en=iram_enable=1 for exactly one cycle, with iram_addr and iram_data valid that same cycle; the cycle is the one after the LO transfer.
REQ-027 On leaving WRITE: word_count+1, addr+1; next state CHK if new word_count==N, else HI.
REQ-028 iram_addr/iram_data SHALL hold their values outside WRITE; the strobe alone qualifies them.
REQ-029 CHK transfer: byte==accumulator -> DONE, else -> ERR.
REQ-030 DONE: cpu_hold=0, load_done=1, held until the next start.
REQ-031 ERR: cpu_hold=1, load_error=1, held until the next start (retry); words already written are not undone.
REQ-032 Address SHALL never wrap; REQ-023 guarantees the last address is at most 255.
REQ-033 Byte transfers need not be back-to-back; byte_valid gaps of any length SHALL only stall.
REQ-034 Minimum load time SHALL be 3N+3 cycles from start to DONE.

Reset
REQ-035 reset==0 at a rising edge -> IDLE; all outputs 0 (byte_ready, iram_*, cpu_hold, load_done, load_error, word_count); accumulator and N cleared.
REQ-036 Reset mid-load SHALL abort with no further write strobe; a write pending in WRITE that same cycle SHALL be suppressed.

Verification
REQ-037 BASE_ADDR=0; start, stream 02,12,34,AB,CD,CHK=12^34^AB^CD=40 -> writes 0x1234@0, 0xABCD@1; DONE, load_done=1, cpu_hold=0, word_count=2.
REQ-038 LEN=00 -> ERR at the next edge, load_error=1, cpu_hold=1, no write strobe; start, then a good stream -> DONE.
REQ-039 N=1, word 0x5A5A, CHK=01 -> one write @0, then ERR, load_error=1.
REQ-040 N=3 with byte_valid toggling every other cycle -> 3 strobes, addresses 0,1,2, data correct; start pulses mid-load have no effect.
REQ-041 reset=0 after the LO byte of word 2 of 4 -> no strobe that cycle, all outputs 0; start, then a full stream -> correct writes from address 0.
REQ-042 BASE_ADDR=250; LEN=07 -> ERR; LEN=06 -> last write @255, DONE.
